// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding, default width and wrap-around step helper for count_seq_ctrl
package count_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int COUNT_SEQ_WIDTH = 3;

   function automatic logic [31:0] step(input logic [31:0] v, input logic up, input int w);
      return (up ? v + 32'd1 : v - 32'd1) & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/count_updn.sv
// count_updn: plain WIDTH-bit wrap-around up/down counter, sole holder of q
module count_updn
   import count_seq_pkg::*;
#(
   parameter int WIDTH = COUNT_SEQ_WIDTH
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   input  logic             vec,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // step one count per enabled edge, wrapping modulo 2**WIDTH
   always_ff @(posedge clk or negedge clrn)
      if (!clrn) r_q <= '0;
      else if (en) r_q <= WIDTH'(step(32'(r_q), vec, WIDTH));

   assign q = r_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: valid/ready command sequencer stepping count_updn to a target, then pulsing done.
// Optional COUNT_SEQ_AUTO_DIR_EN: direction chosen as the shorter way round (tie -> up), cmd_dir ignored.
module count_seq_ctrl
   import count_seq_pkg::*;
#(
   parameter int WIDTH = COUNT_SEQ_WIDTH
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic             cmd_dir,
   output logic             vec,
   output logic             cnt_en,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_tgt, w_step;
   logic             r_dir, w_dir_sel, w_accept;

   assign w_accept = (r_state == IDLE) && cmd_valid;
   assign w_step   = WIDTH'(step(32'(q), r_dir, WIDTH));
   assign vec      = r_dir;

`ifdef COUNT_SEQ_AUTO_DIR_EN
   logic [WIDTH-1:0] w_up_dist, w_dn_dist;
   assign w_up_dist = cmd_target - q;
   assign w_dn_dist = q - cmd_target;
   assign w_dir_sel = (w_up_dist <= w_dn_dist);
`else
   assign w_dir_sel = cmd_dir;
`endif

   count_updn #(.WIDTH(WIDTH)) u_cnt (
      .clk  (clk),
      .clrn (clrn),
      .en   (cnt_en),
      .vec  (r_dir),
      .q    (q)
   );

   // state register; target and direction latched on command acceptance, held otherwise
   always_ff @(posedge clk or negedge clrn)
      if (!clrn) begin
         r_state <= IDLE;
         r_tgt   <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_tgt <= cmd_target;
            r_dir <= w_dir_sel;
         end
      end

   // next state and Moore outputs; RUN leaves on the edge whose stepped value hits the target
   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      cnt_en    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) w_next = (cmd_target == q) ? DONE : RUN;
         end
         RUN: begin
            cnt_en = 1'b1;
            if (w_step == r_tgt) w_next = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule
